// File: rtl/lfsr_gen_if.sv
// Purpose: bundles the reseed port, the valid/ready output stream and the status
//          signals of lfsr_gen.
// Ports (master = generator side):
//   seed_valid/seed_data  in   reseed request and the new seed
//   seed_err              out  one-cycle pulse when a lock-up seed was replaced by INIT
//   out_valid/out_ready   out/in  output stream handshake
//   out_data              out  top OUT_W bits of the state
//   state                 out  raw LFSR state
//   busy                  out  high while warming up
interface lfsr_gen_if #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned OUT_W = 1
) ();
  logic             seed_valid;
  logic [WIDTH-1:0] seed_data;
  logic             seed_err;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [WIDTH-1:0] state;
  logic             busy;

  modport master (
    input  seed_valid, seed_data, out_ready,
    output seed_err, out_valid, out_data, state, busy
  );

  modport slave (
    output seed_valid, seed_data, out_ready,
    input  seed_err, out_valid, out_data, state, busy
  );
endinterface

// File: rtl/lfsr_gen.sv
// Purpose: parametrised Fibonacci LFSR with leap-forward output (OUT_W steps per accept),
//          runtime reseed with lock-up guard, post-seed warm-up and a valid/ready stream.
// Ports:
//   clk   in  clock, all state on rising edge
//   rst   in  asynchronous active-high reset
//   bus   lfsr_gen_if.master: seed_valid/seed_data/seed_err, out_valid/out_ready/out_data,
//         state, busy
module lfsr_gen #(
  parameter int unsigned      WIDTH  = 128,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(128'hA0000014_00000000_00000000_00000000),
  parameter logic [WIDTH-1:0] INIT   = WIDTH'(128'h001bb69a_baf65811_caa417d1_19362a08),
  parameter bit               XNOR   = 1'b1,
  parameter int unsigned      OUT_W  = 1,
  parameter int unsigned      WARMUP = 0
) (
  input  logic        clk,
  input  logic        rst,
  lfsr_gen_if.master  bus
);

  localparam logic [WIDTH-1:0] LK    = XNOR ? '1 : '0;
  localparam int unsigned      CNT_W = (WARMUP < 2) ? 1 : $clog2(WARMUP + 1);

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } fsm_e;

  localparam fsm_e             FSM_START = (WARMUP == 0) ? RUN : WARM;
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(WARMUP);

  // Parameter sanity: any of these makes the generator meaningless or stuck.
  if (OUT_W > WIDTH || OUT_W < 1 || WIDTH < 4 || TAPS == '0 || INIT == LK) begin : g_param_err
    $error("lfsr_gen: illegal parameter set (OUT_W/WIDTH/TAPS/INIT)");
  end

  fsm_e             fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic             seed_err_q, seed_err_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             seed_lk;

  // OUT_W single shifts unrolled into one combinational advance.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] r;
    logic             fb;
    r = s;
    for (int i = 0; i < int'(OUT_W); i++) begin
      fb = (^(r & TAPS)) ^ XNOR;
      r  = {r[WIDTH-2:0], fb};
    end
    return r;
  endfunction

  assign seed_lk = (bus.seed_data == LK);

  // Next-state: reseed beats everything, then warm-up or handshake-driven advance.
  always_comb begin
    fsm_d      = fsm_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    seed_err_d = 1'b0;
    if (bus.seed_valid) begin
      state_d    = seed_lk ? INIT : bus.seed_data;
      seed_err_d = seed_lk;
      fsm_d      = FSM_START;
      cnt_d      = CNT_START;
    end else begin
      unique case (fsm_q)
        WARM: begin
          state_d = advance(state_q);
          if (cnt_q <= CNT_W'(1)) begin
            fsm_d = RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        RUN: begin
          if (out_valid_q && bus.out_ready) begin
            state_d = advance(state_q);
          end
        end
        default: fsm_d = FSM_START;
      endcase
    end
    out_valid_d = (fsm_d == RUN);
    busy_d      = (fsm_d == WARM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= FSM_START;
      cnt_q       <= CNT_START;
      state_q     <= INIT;
      seed_err_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= (FSM_START == WARM);
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      seed_err_q  <= seed_err_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.seed_err  = seed_err_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = state_q[WIDTH-1 -: OUT_W];
  assign bus.state     = state_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: default 128-bit XNOR instance, 4-bit XOR instances with OUT_W=1 and
// OUT_W=4, and a 128-bit instance with WARMUP=3.
module tb_lfsr_gen;

  localparam logic [127:0] D_INIT  = 128'h001bb69a_baf65811_caa417d1_19362a08;
  localparam logic [127:0] D_TAPS  = 128'hA0000014_00000000_00000000_00000000;
  localparam logic [127:0] D_STEP1 = 128'h00376d35_75ecb023_95482fa2_326c5410;
  localparam logic [3:0]   S_INIT  = 4'b1001;
  localparam logic [3:0]   S_TAPS  = 4'b1100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lfsr_gen_if #(.WIDTH(128), .OUT_W(1)) if0 ();
  lfsr_gen_if #(.WIDTH(4),   .OUT_W(1)) if1 ();
  lfsr_gen_if #(.WIDTH(4),   .OUT_W(4)) if2 ();
  lfsr_gen_if #(.WIDTH(128), .OUT_W(1)) if3 ();

  lfsr_gen u0 (.clk(clk), .rst(rst), .bus(if0));
  lfsr_gen #(.WIDTH(4), .TAPS(S_TAPS), .INIT(S_INIT), .XNOR(1'b0), .OUT_W(1)) u1 (
    .clk(clk), .rst(rst), .bus(if1));
  lfsr_gen #(.WIDTH(4), .TAPS(S_TAPS), .INIT(S_INIT), .XNOR(1'b0), .OUT_W(4)) u2 (
    .clk(clk), .rst(rst), .bus(if2));
  lfsr_gen #(.WARMUP(3)) u3 (.clk(clk), .rst(rst), .bus(if3));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: the spec's single-step rule applied n times on a masked integer.
  function automatic logic [127:0] ref_adv(input logic [127:0] s, input logic [127:0] taps,
                                           input int w, input bit xn, input int n);
    logic [127:0] mask;
    logic         p;
    mask = (w == 128) ? '1 : ((128'd1 << w) - 128'd1);
    for (int i = 0; i < n; i++) begin
      p = (^(s & taps)) ^ xn;
      s = ((s << 1) | 128'(p)) & mask;
    end
    return s;
  endfunction

  task automatic idle_all();
    if0.seed_valid = 1'b0; if0.seed_data = '0; if0.out_ready = 1'b0;
    if1.seed_valid = 1'b0; if1.seed_data = '0; if1.out_ready = 1'b0;
    if2.seed_valid = 1'b0; if2.seed_data = '0; if2.out_ready = 1'b0;
    if3.seed_valid = 1'b0; if3.seed_data = '0; if3.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       sv;
    logic [3:0] sd;
    logic       rd;
    logic [3:0] st;
    logic       vld;
    logic       err;
  } vec_t;

  vec_t tbl [10];

  // Random-phase model, per instance: 0 = u0, 1 = u1, 2 = u2
  logic [127:0] m_st  [3];
  logic         m_vld [3];
  logic         m_err [3];
  int           c_w   [3] = '{128, 4, 4};
  int           c_ow  [3] = '{1, 1, 4};
  bit           c_xn  [3] = '{1'b1, 1'b0, 1'b0};

  function automatic logic [127:0] c_taps(input int k);
    return (k == 0) ? D_TAPS : 128'(S_TAPS);
  endfunction

  function automatic logic [127:0] c_init(input int k);
    return (k == 0) ? D_INIT : 128'(S_INIT);
  endfunction

  task automatic mupd(input int k, input logic sv, input logic [127:0] sd, input logic rd);
    logic [127:0] lk;
    lk = c_xn[k] ? ((c_w[k] == 128) ? '1 : ((128'd1 << c_w[k]) - 128'd1)) : '0;
    if (sv) begin
      m_err[k] = (sd == lk);
      m_st[k]  = m_err[k] ? c_init(k) : sd;
    end else begin
      m_err[k] = 1'b0;
      if (m_vld[k] && rd) m_st[k] = ref_adv(m_st[k], c_taps(k), c_w[k], c_xn[k], c_ow[k]);
    end
    m_vld[k] = 1'b1;
  endtask

  function automatic logic [127:0] mdata(input int k);
    return (m_st[k] >> (c_w[k] - c_ow[k])) & ((128'd1 << c_ow[k]) - 128'd1);
  endfunction

  initial begin
    logic [3:0]   s4 [16];
    bit           seen [16];
    int           distinct;
    logic [3:0]   bits;
    logic [3:0]   d2;
    logic [127:0] held;
    logic [127:0] sd [3];
    logic         sv [3];
    logic         rd [3];

    tbl[0] = '{1'b0, 4'h0,    1'b1, 4'b1001, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 4'h0,    1'b1, 4'b0011, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 4'h0,    1'b0, 4'b0011, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 4'b0000, 1'b1, 4'b1001, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 4'h0,    1'b1, 4'b0011, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 4'b0110, 1'b1, 4'b0110, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 4'h0,    1'b1, 4'b1101, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 4'b1111, 1'b0, 4'b1111, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 4'h0,    1'b1, 4'b1110, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 4'h0,    1'b0, 4'b1110, 1'b1, 1'b0};

    // Reset values and first accept on the default configuration
    do_reset();
    chk("rst_state0", if0.state, D_INIT);
    chk("rst_valid0", 128'(if0.out_valid), 128'd0);
    chk("rst_err0",   128'(if0.seed_err), 128'd0);
    chk("rst_busy0",  128'(if0.busy), 128'd0);
    chk("rst_busy3",  128'(if3.busy), 128'd1);
    @(posedge clk); #1;
    chk("t1_valid", 128'(if0.out_valid), 128'd1);
    chk("t1_hold",  if0.state, D_INIT);
    if0.out_ready = 1'b1;
    @(posedge clk); #1;
    if0.out_ready = 1'b0;
    chk("t1_state", if0.state, D_STEP1);
    chk("t1_data",  128'(if0.out_data), 128'd0);

    // Table-driven vectors on the 4-bit OUT_W=1 instance
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if1.seed_valid = tbl[i].sv;
      if1.seed_data  = tbl[i].sd;
      if1.out_ready  = tbl[i].rd;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_state", i), 128'(if1.state), 128'(tbl[i].st));
      chk($sformatf("tbl%0d_valid", i), 128'(if1.out_valid), 128'(tbl[i].vld));
      chk($sformatf("tbl%0d_err", i),   128'(if1.seed_err), 128'(tbl[i].err));
      chk($sformatf("tbl%0d_data", i),  128'(if1.out_data), 128'(tbl[i].st[3]));
    end

    // Full period from seed 0001: 15 distinct states, 16th returns to the seed
    if1.seed_valid = 1'b1; if1.seed_data = 4'b0001; if1.out_ready = 1'b1;
    @(posedge clk); #1;
    if1.seed_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s4[i] = if1.state;
      @(posedge clk); #1;
    end
    distinct = 0;
    for (int i = 0; i < 16; i++) seen[i] = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (!seen[s4[i]]) distinct++;
      seen[s4[i]] = 1'b1;
    end
    chk("t2_distinct", 128'(distinct), 128'd15);
    chk("t2_wrap",     128'(s4[15]), 128'd1);
    chk("t2_first",    128'(s4[0]), 128'd1);
    if1.out_ready = 1'b0;

    // Leap-forward: one OUT_W=4 accept equals four OUT_W=1 accepts
    if1.seed_valid = 1'b1; if1.seed_data = 4'b0001;
    if2.seed_valid = 1'b1; if2.seed_data = 4'b0001;
    @(posedge clk); #1;
    if1.seed_valid = 1'b0; if2.seed_valid = 1'b0;
    d2 = if2.out_data;
    bits = '0;
    for (int k = 0; k < 4; k++) begin
      bits = {bits[2:0], if1.out_data};
      if1.out_ready = 1'b1;
      if2.out_ready = (k == 0);
      @(posedge clk); #1;
    end
    if1.out_ready = 1'b0; if2.out_ready = 1'b0;
    chk("t4_bits4", 128'(d2), 128'b0001);
    chk("t4_bits1", 128'(bits), 128'b0001);
    chk("t4_state4", 128'(if2.state), ref_adv(128'd1, 128'(S_TAPS), 4, 1'b0, 4));
    chk("t4_state1", 128'(if1.state), ref_adv(128'd1, 128'(S_TAPS), 4, 1'b0, 4));

    // Warm-up of three accepts' worth after reset
    do_reset();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("t5_valid%0d", c), 128'(if3.out_valid), 128'd0);
      chk($sformatf("t5_busy%0d", c),  128'(if3.busy), 128'd1);
      @(posedge clk); #1;
    end
    chk("t5_valid", 128'(if3.out_valid), 128'd1);
    chk("t5_busy",  128'(if3.busy), 128'd0);
    chk("t5_state", if3.state, ref_adv(D_INIT, D_TAPS, 128, 1'b1, 3));
    @(posedge clk); #1;
    chk("t5_hold",  if3.state, ref_adv(D_INIT, D_TAPS, 128, 1'b1, 3));

    // Randomised traffic on three instances against the reference model
    do_reset();
    for (int k = 0; k < 3; k++) begin
      m_st[k] = c_init(k); m_vld[k] = 1'b0; m_err[k] = 1'b0;
    end
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int k = 0; k < 3; k++) begin
        sv[k] = ($urandom_range(11) == 0);
        rd[k] = 1'(($urandom_range(3)) != 0);
        sd[k] = {$urandom, $urandom, $urandom, $urandom};
        if (k != 0) sd[k] = sd[k] & 128'hF;
        if ($urandom_range(3) == 0) sd[k] = (k == 0) ? '1 : '0;
      end
      if0.seed_valid = sv[0]; if0.seed_data = sd[0];     if0.out_ready = rd[0];
      if1.seed_valid = sv[1]; if1.seed_data = 4'(sd[1]); if1.out_ready = rd[1];
      if2.seed_valid = sv[2]; if2.seed_data = 4'(sd[2]); if2.out_ready = rd[2];
      @(posedge clk);
      for (int k = 0; k < 3; k++) mupd(k, sv[k], sd[k], rd[k]);
      #1;
      chk($sformatf("rnd%0d_st0", cyc),  if0.state, m_st[0]);
      chk($sformatf("rnd%0d_st1", cyc),  128'(if1.state), m_st[1]);
      chk($sformatf("rnd%0d_st2", cyc),  128'(if2.state), m_st[2]);
      chk($sformatf("rnd%0d_v0", cyc),   128'(if0.out_valid), 128'(m_vld[0]));
      chk($sformatf("rnd%0d_e0", cyc),   128'(if0.seed_err), 128'(m_err[0]));
      chk($sformatf("rnd%0d_e1", cyc),   128'(if1.seed_err), 128'(m_err[1]));
      chk($sformatf("rnd%0d_d0", cyc),   128'(if0.out_data), mdata(0));
      chk($sformatf("rnd%0d_d2", cyc),   128'(if2.out_data), mdata(2));
    end
    idle_all();

    // Back-pressure then reseed with same-cycle accept, then async reset mid-stream
    @(posedge clk); #1;
    held = if0.state;
    chk("t6_pre", held, m_st[0]);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("t6_stall%0d", c), if0.state, m_st[0]);
    end
    if0.seed_valid = 1'b1; if0.out_ready = 1'b1;
    if0.seed_data  = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    @(posedge clk); #1;
    if0.seed_valid = 1'b0; if0.out_ready = 1'b0;
    chk("t6_seed",  if0.state, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
    chk("t6_valid", 128'(if0.out_valid), 128'd1);
    chk("t6_data",  128'(if0.out_data), 128'd0);
    @(posedge clk); #1;
    chk("t6_noadv", if0.state, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_state", if0.state, D_INIT);
    chk("t6_async_valid", 128'(if0.out_valid), 128'd0);
    chk("t6_async_st1",   128'(if1.state), 128'(S_INIT));
    @(posedge clk); #1;
    chk("t6_rst_hold", if0.state, D_INIT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
